// File: rtl/cu_return_arbiter_pkg.sv
// Shared AFU definitions: the return-arbiter state encoding and the
// cu_return_done status-word layout ([0:63] bit numbering, bit 0 = MSB).
package AFU_PKG;

  typedef enum logic [1:0] {IDLE, POST, CLEAR} cu_return_state_t;

  localparam int CU_RETURN_DONE_VALID_BIT = 63;
  localparam int CU_RETURN_DONE_ID_MSB    = 0;
  localparam int CU_RETURN_DONE_ID_LSB    = 7;

  // Builds the posted status word: CU index in [0:7], valid flag in [63].
  function automatic logic [0:63] cu_return_done_word(input logic [7:0] id);
    logic [0:63] w;
    w = '0;
    w[CU_RETURN_DONE_ID_MSB:CU_RETURN_DONE_ID_LSB] = id;
    w[CU_RETURN_DONE_VALID_BIT] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/cu_return_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after
// (last_grant + 1) mod NUM_REQ, wrapping.
module round_robin_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_grant
);

  logic [IDX_W:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    cand      = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      cand = {1'b0, last_grant} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) begin
        cand = cand - (IDX_W+1)'(NUM_REQ);
      end
      if (req[cand[IDX_W-1:0]]) begin
        grant_idx = cand[IDX_W-1:0];
        any_grant = 1'b1;
      end
    end
    grant = NUM_REQ'(any_grant) << grant_idx;
  end

endmodule

// File: rtl/cu_return_arbiter.sv
// Serialises per-CU completion reports onto the host-polled cu_return /
// cu_return_done pair, one at a time, round-robin, held until acknowledged.
module cu_return_arbiter
  import AFU_PKG::*;
#(
  parameter int NUM_CU = 4
) (
  input  logic                   clock,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic [NUM_CU-1:0]      cu_done_valid,
  input  logic [NUM_CU-1:0][0:63] cu_done_value,
  output logic [NUM_CU-1:0]      cu_done_ready,
  input  logic                   cu_return_done_ack,
  output logic [0:63]            cu_return,
  output logic [0:63]            cu_return_done,
  output logic [NUM_CU-1:0]      pending_mask,
  output logic [31:0]            done_count,
  output logic                   spurious_ack
);

  localparam int IDX_W = (NUM_CU > 1) ? $clog2(NUM_CU) : 1;

  cu_return_state_t  state_reg, state_next;
  logic [IDX_W-1:0]  last_grant_reg;
  logic [NUM_CU-1:0] rr_grant;
  logic [IDX_W-1:0]  rr_idx;
  logic              rr_any;
  logic              transfer;

  logic [0:63]       cu_return_reg;
  logic [0:63]       cu_return_done_reg;
  logic [NUM_CU-1:0] pending_mask_reg;
  logic [31:0]       done_count_reg;
  logic              spurious_ack_reg;

  round_robin_arbiter #(
    .NUM_REQ (NUM_CU),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req        (cu_done_valid),
    .last_grant (last_grant_reg),
    .grant      (rr_grant),
    .grant_idx  (rr_idx),
    .any_grant  (rr_any)
  );

  // Ready is gated by rstn so no CU sees an accept while reset is held.
  always_comb begin
    state_next    = state_reg;
    cu_done_ready = '0;
    transfer      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (rstn && enable && rr_any) begin
          cu_done_ready = rr_grant;
          transfer      = 1'b1;
          state_next    = POST;
        end
      end
      POST: begin
        if (cu_return_done_ack) state_next = CLEAR;
      end
      CLEAR: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A report posted when reset hits is dropped; its CU already saw the transfer.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_reg          <= IDLE;
      last_grant_reg     <= IDX_W'(NUM_CU - 1);
      cu_return_reg      <= '0;
      cu_return_done_reg <= '0;
      pending_mask_reg   <= '0;
      done_count_reg     <= '0;
      spurious_ack_reg   <= 1'b0;
    end else begin
      state_reg        <= state_next;
      pending_mask_reg <= cu_done_valid;
      spurious_ack_reg <= cu_return_done_ack && (state_reg != POST);
      if (transfer) begin
        last_grant_reg     <= rr_idx;
        cu_return_reg      <= cu_done_value[rr_idx];
        cu_return_done_reg <= cu_return_done_word(8'(rr_idx));
      end
      if (state_reg == POST && cu_return_done_ack) begin
        done_count_reg <= done_count_reg + 32'd1;
      end
      if (state_reg == CLEAR) begin
        cu_return_reg      <= '0;
        cu_return_done_reg <= '0;
      end
    end
  end

  assign cu_return      = cu_return_reg;
  assign cu_return_done = cu_return_done_reg;
  assign pending_mask   = pending_mask_reg;
  assign done_count     = done_count_reg;
  assign spurious_ack   = spurious_ack_reg;

endmodule

// File: doc/cu_return_arbiter.md
# cu_return_arbiter

Collects per-compute-unit completion reports (64-bit return value plus done flag) and serialises them, one at a time and in round-robin order, onto the single `cu_return` / `cu_return_done` register pair that the host polls over MMIO. Each report stays posted until the host writes `CU_RETURN_DONE_ACK`; the arbiter then clears the pair and grants the next CU. It sits between the CU array and the MMIO block, and is fed by that block's `cu_return_done_ack` pulse.

## Interface
Parameters:
- `NUM_CU`, 4, number of compute-unit requesters (1..256).

Ports:
- `clock`  in  1  clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `enable`  in  1  new grants permitted when high; normally `afu_configure[63]`.
- `cu_done_valid`  in  NUM_CU  per-CU report pending.
- `cu_done_value`  in  NUM_CU x 64  per-CU return value, `[0:63]` ordering.
- `cu_done_ready`  out  NUM_CU  one-hot accept; a transfer occurs when valid & ready are both high.
- `cu_return_done_ack`  in  1  single-cycle host acknowledge from MMIO.
- `cu_return`  out 64  posted return value.
- `cu_return_done`  out 64  posted status word.
- `pending_mask`  out NUM_CU  registered copy of `cu_done_valid`.
- `done_count`  out 32  total reports acknowledged by the host.
- `spurious_ack`  out 1  pulse when an ack arrives with nothing posted.

## Operation
- The FSM has three states:
  - `IDLE`: grants a report.
  - `POST`: holds the report for the host.
  - `CLEAR`: drives zeros for one cycle.
- `IDLE` behaviour:
  - If `enable` is high and any valid bit is set, drive `cu_done_ready` high combinationally for exactly the winner.
  - The winner is the first valid CU searched from `(last_grant+1) mod NUM_CU` upward, wrapping.
  - On the transfer edge: register `last_grant`, `cu_return <= cu_done_value[winner]`, and `cu_return_done` per the layout below. Go to `POST`.
- `cu_return_done` layout: bits `[0:7]` hold the winner index, zero-extended; bit `[63]` = 1; all other bits 0.
- `POST`: `cu_done_ready` = 0. When `cu_return_done_ack` is seen, increment `done_count` and go to `CLEAR`.
- `CLEAR`: `cu_return` and `cu_return_done` <= 0. Go to `IDLE`. No grant is made in this cycle.
- Ack in `IDLE` or `CLEAR`: pulse `spurious_ack` for 1 cycle; no other effect.
- `enable` low:
  - In `IDLE`, no grant is made.
  - A posted report is unaffected and is still acknowledged normally.
- CU contract: `cu_done_value` must be held stable while valid is high and ready is low. Dropping valid before ready is permitted; that CU then loses its slot.
- `done_count` wraps from 0xFFFF_FFFF to 0.

## Timing
- Reset values of all outputs: `cu_return` = 0, `cu_return_done` = 0, `cu_done_ready` = 0, `pending_mask` = 0, `done_count` = 0, `spurious_ack` = 0.
- Reset state: state = `IDLE`, `last_grant` = NUM_CU-1, so CU0 wins first.
- Grant latency: if valid is high at edge t in `IDLE`, ready is high during cycle t and outputs are posted after edge t (visible at t+1).
- Clear latency:
  - Ack sampled at edge t in `POST` → zeros visible after t+1.
  - Earliest next grant is the cycle after that, so outputs are non-zero at t+3 at the earliest.
  - The minimum 1-cycle zero window guarantees the host observes the clear.
- Simultaneous ack and new valid in `POST`: the ack is processed, and the new valid waits for `IDLE`.
- `pending_mask`: one-cycle registered delay of `cu_done_valid`.
- Reset asserted mid-`POST`: the posted report is discarded. The CU already saw its transfer, so the loss is accepted and documented as such.

## Structure
- Shared package `AFU_PKG` holds:
  - `typedef enum logic [1:0] {IDLE, POST, CLEAR} cu_return_state_t`.
  - Constants `CU_RETURN_DONE_VALID_BIT = 63`, `CU_RETURN_DONE_ID_MSB = 0`, `CU_RETURN_DONE_ID_LSB = 7`.
- Sub-module `round_robin_arbiter #(NUM_REQ)`: combinational. Inputs are the request vector and `last_grant`; outputs are the one-hot grant, the grant index, and `any_grant`.
- This top contains the FSM, output registers, counter and spurious-ack logic.

## Test plan
- Reset, then CU2 valid with value `0xDEAD_BEEF_0000_0001`:
  - `cu_done_ready` = 0b0100 for 1 cycle.
  - Next cycle `cu_return` = that value and `cu_return_done` = `0x0200_0000_0000_0001`.
  - Ack → one zero cycle, then `done_count` = 1.
- All four CUs valid continuously, host acks each post: grant order 0,1,2,3,0; zero cycle between each; `done_count` = 5.
- Ack pulse in `IDLE`: `spurious_ack` = 1 for 1 cycle; state, outputs and `done_count` unchanged.
- `enable` low with CU1 valid: no ready and outputs stay 0. Raise `enable` → CU1 granted in that same cycle.
- Async reset asserted while in `POST` with CU3 posted: outputs 0 immediately; after release, CU0 has first priority.
- Preload `done_count` = 0xFFFF_FFFF via a force, then one ack: `done_count` wraps to 0.
